// File: rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv
// ============================================================================
// Module  : ysyx_22041071_axi_rd_arbiter_pkg
// Brief   : Shared encodings and bus widths for the AXI read-channel arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_22041071_axi_rd_arbiter_pkg;

  localparam int ADDR_BUS      = 64;
  localparam int AXI_LEN_WIDTH = 8;
  localparam int SIZE_D        = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ysyx_22041071_arb_pick.sv
// ============================================================================
// Module  : ysyx_22041071_arb_pick
// Brief   : Two-input grant picker; fixed MEM-over-IF priority, or round-robin
//           with a last_grant flop when YSYX_22041071_ARB_RR_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22041071_arb_pick
  import ysyx_22041071_axi_rd_arbiter_pkg::*;
(
`ifdef YSYX_22041071_ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic req_if,
  input  logic req_mem,
  output logic gnt_if,
  output logic gnt_mem
);

`ifdef YSYX_22041071_ARB_RR_EN
  logic r_last_grant;

  // Starts at MEM so that IF wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= OWN_MEM;
    end else if (gnt_if || gnt_mem) begin
      r_last_grant <= gnt_mem ? OWN_MEM : OWN_IF;
    end
  end

  always_comb begin
    gnt_if  = req_if && (!req_mem || (r_last_grant == OWN_MEM));
    gnt_mem = req_mem && !gnt_if;
  end
`else
  always_comb begin
    gnt_mem = req_mem;
    gnt_if  = req_if && !req_mem;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ysyx_22041071_axi_rd_arbiter.sv
// ============================================================================
// Module  : ysyx_22041071_axi_rd_arbiter
// Brief   : Shares one AXI4 read channel between IF and MEM, one transaction
//           at a time. Option macro: YSYX_22041071_ARB_RR_EN (round-robin).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_22041071_axi_rd_arbiter
  import ysyx_22041071_axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int DATA_W = 64,
  parameter int LEN_W  = AXI_LEN_WIDTH,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_ar_valid,
  output logic              if_ar_ready,
  input  logic [ADDR_W-1:0] if_ar_addr,
  input  logic [LEN_W-1:0]  if_ar_len,
  input  logic [2:0]        if_ar_size,
  output logic              if_r_valid,
  input  logic              if_r_ready,
  output logic [DATA_W-1:0] if_r_data,
  output logic [1:0]        if_r_resp,
  output logic              if_r_last,
  input  logic              mem_ar_valid,
  output logic              mem_ar_ready,
  input  logic [ADDR_W-1:0] mem_ar_addr,
  input  logic [LEN_W-1:0]  mem_ar_len,
  input  logic [2:0]        mem_ar_size,
  output logic              mem_r_valid,
  input  logic              mem_r_ready,
  output logic [DATA_W-1:0] mem_r_data,
  output logic [1:0]        mem_r_resp,
  output logic              mem_r_last,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [LEN_W-1:0]  axi_ar_len,
  output logic [2:0]        axi_ar_size,
  output logic [ID_W-1:0]   axi_ar_id,
  output logic [1:0]        axi_ar_burst,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic [1:0]        axi_r_resp,
  input  logic              axi_r_last,
  input  logic [ID_W-1:0]   axi_r_id
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_ar_addr;
  logic [LEN_W-1:0]    r_ar_len;
  logic [SIZE_D-1:0]   r_ar_size;

  logic                w_idle;
  logic                w_data;
  logic                w_req_if;
  logic                w_req_mem;
  logic                w_gnt_if;
  logic                w_gnt_mem;
  logic                w_grant;
  logic                w_owner_rready;
  logic [ID_W-1:0]     w_owner_id;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_data    = (r_state == ST_DATA);
  assign w_req_if  = w_idle && if_ar_valid;
  assign w_req_mem = w_idle && mem_ar_valid;
  assign w_grant   = w_gnt_if || w_gnt_mem;

  ysyx_22041071_arb_pick u_pick (
`ifdef YSYX_22041071_ARB_RR_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .req_if  (w_req_if),
    .req_mem (w_req_mem),
    .gnt_if  (w_gnt_if),
    .gnt_mem (w_gnt_mem)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)                                  w_state_nxt = ST_ADDR;
      ST_ADDR: if (axi_ar_ready)                             w_state_nxt = ST_DATA;
      ST_DATA: if (axi_r_valid && axi_r_ready && axi_r_last) w_state_nxt = ST_IDLE;
      default:                                               w_state_nxt = ST_IDLE;
    endcase
  end

  // AR payload is captured at grant so the requester is free once ar_ready pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_IF;
      r_ar_addr <= '0;
      r_ar_len  <= '0;
      r_ar_size <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner   <= w_gnt_mem ? OWN_MEM : OWN_IF;
        r_ar_addr <= w_gnt_mem ? mem_ar_addr : if_ar_addr;
        r_ar_len  <= w_gnt_mem ? mem_ar_len  : if_ar_len;
        r_ar_size <= w_gnt_mem ? mem_ar_size : if_ar_size;
      end
    end
  end

  assign if_ar_ready  = w_gnt_if;
  assign mem_ar_ready = w_gnt_mem;

  assign w_owner_id   = {{(ID_W-1){1'b0}}, r_owner};
  assign axi_ar_valid = (r_state == ST_ADDR);
  assign axi_ar_addr  = r_ar_addr;
  assign axi_ar_len   = r_ar_len;
  assign axi_ar_size  = r_ar_size;
  assign axi_ar_id    = w_owner_id;
  assign axi_ar_burst = BURST_INCR;

  assign w_owner_rready = (r_owner == OWN_MEM) ? mem_r_ready : if_r_ready;
  assign axi_r_ready    = w_data && w_owner_rready;

  assign if_r_valid  = w_data && (r_owner == OWN_IF)  && axi_r_valid;
  assign mem_r_valid = w_data && (r_owner == OWN_MEM) && axi_r_valid;
  assign if_r_data   = axi_r_data;
  assign if_r_resp   = axi_r_resp;
  assign if_r_last   = axi_r_last;
  assign mem_r_data  = axi_r_data;
  assign mem_r_resp  = axi_r_resp;
  assign mem_r_last  = axi_r_last;

  property p_rid_matches_owner;
    @(posedge clk) disable iff (reset)
      (w_data && axi_r_valid) |-> (axi_r_id == w_owner_id);
  endproperty
  a_rid_matches_owner: assert property (p_rid_matches_owner);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041071_axi_rd_arbiter.sv
// ============================================================================
// Module  : tb_ysyx_22041071_axi_rd_arbiter
// Brief   : Self-checking bench with a transaction-level model of the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22041071_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_ar_valid, if_ar_ready, if_r_valid, if_r_ready, if_r_last;
  logic [63:0] if_ar_addr, if_r_data;
  logic [7:0]  if_ar_len;
  logic [2:0]  if_ar_size;
  logic [1:0]  if_r_resp;
  logic        mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_ready, mem_r_last;
  logic [63:0] mem_ar_addr, mem_r_data;
  logic [7:0]  mem_ar_len;
  logic [2:0]  mem_ar_size;
  logic [1:0]  mem_r_resp;
  logic        axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready, axi_r_last;
  logic [63:0] axi_ar_addr, axi_r_data;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [3:0]  axi_ar_id, axi_r_id;
  logic [1:0]  axi_ar_burst, axi_r_resp;

  always #5 clk = ~clk;

  ysyx_22041071_axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .if_ar_valid(if_ar_valid), .if_ar_ready(if_ar_ready), .if_ar_addr(if_ar_addr),
    .if_ar_len(if_ar_len), .if_ar_size(if_ar_size), .if_r_valid(if_r_valid),
    .if_r_ready(if_r_ready), .if_r_data(if_r_data), .if_r_resp(if_r_resp), .if_r_last(if_r_last),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
    .mem_ar_len(mem_ar_len), .mem_ar_size(mem_ar_size), .mem_r_valid(mem_r_valid),
    .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp), .mem_r_last(mem_r_last),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size), .axi_ar_id(axi_ar_id),
    .axi_ar_burst(axi_ar_burst), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id)
  );

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level model: phase 0 = channel free, 1 = address owed, 2 = beats owed.
  int          phase;
  logic        own;
  logic [63:0] t_addr;
  logic [7:0]  t_len;
  logic [2:0]  t_size;
  int          beat;
  logic        lg_mem;
  logic        r_hold;
  logic [63:0] h_data;
  logic [1:0]  h_resp;
  bit          known = 0;

  // Requesters keep a request pending until it is granted.
  logic        if_pend = 0, mem_pend = 0;
  logic [63:0] if_addr, mem_addr;
  logic [7:0]  if_len, mem_len;
  logic [2:0]  if_size, mem_size;

  logic        k_reset, k_arready, k_if_rr, k_mem_rr, k_rvalid, k_stray;
  logic [63:0] k_rdata;
  logic [1:0]  k_rresp;

  logic        s_if_arr, s_mem_arr, s_arv, s_rready, s_if_rv, s_mem_rv, s_if_last, s_mem_last;
  logic [3:0]  s_arid;
  logic [63:0] s_araddr, s_if_data, s_mem_data;
  logic [1:0]  s_if_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet();
    k_reset = 0; k_arready = 0; k_if_rr = 0; k_mem_rr = 0;
    k_rvalid = 0; k_stray = 0; k_rdata = '0; k_rresp = 2'b00;
  endtask

  task automatic rand_knobs(input bit allow_new);
    k_reset   = 0;
    k_arready = 1'($urandom_range(0, 1));
    k_if_rr   = ($urandom_range(0, 3) != 0);
    k_mem_rr  = ($urandom_range(0, 3) != 0);
    k_rvalid  = ($urandom_range(0, 2) != 0);
    k_stray   = ($urandom_range(0, 3) == 0);
    k_rdata   = {$urandom, $urandom};
    k_rresp   = 2'($urandom_range(0, 3));
    if (allow_new && !if_pend && $urandom_range(0, 3) == 0) begin
      if_pend = 1; if_addr = {$urandom, $urandom};
      if_len = 8'($urandom_range(0, 3)); if_size = 3'($urandom_range(0, 3));
    end
    if (allow_new && !mem_pend && $urandom_range(0, 3) == 0) begin
      mem_pend = 1; mem_addr = {$urandom, $urandom};
      mem_len = 8'($urandom_range(0, 3)); mem_size = 3'($urandom_range(0, 3));
    end
  endtask

  task automatic step();
    logic win_mem, any_req, e_rr, owner_rr;
    reset        = k_reset;
    if_ar_valid  = if_pend;  if_ar_addr  = if_addr;  if_ar_len  = if_len;  if_ar_size  = if_size;
    mem_ar_valid = mem_pend; mem_ar_addr = mem_addr; mem_ar_len = mem_len; mem_ar_size = mem_size;
    axi_ar_ready = k_arready;
    if_r_ready   = k_if_rr;
    mem_r_ready  = k_mem_rr;
    if (known && phase == 2) begin
      if (!r_hold) begin h_data = k_rdata; h_resp = k_rresp; end
      axi_r_valid = r_hold || k_rvalid;
      axi_r_data  = h_data;
      axi_r_resp  = h_resp;
      axi_r_last  = (beat == int'(t_len));
      axi_r_id    = {3'b000, own};
    end else begin
      axi_r_valid = k_stray;
      axi_r_data  = k_rdata;
      axi_r_resp  = k_rresp;
      axi_r_last  = 1'($urandom_range(0, 1));
      axi_r_id    = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    s_if_arr = if_ar_ready; s_mem_arr = mem_ar_ready; s_arv = axi_ar_valid; s_rready = axi_r_ready;
    s_if_rv = if_r_valid; s_mem_rv = mem_r_valid; s_if_last = if_r_last; s_mem_last = mem_r_last;
    s_arid = axi_ar_id; s_araddr = axi_ar_addr; s_if_data = if_r_data; s_mem_data = mem_r_data;
    s_if_resp = if_r_resp;

`ifdef YSYX_22041071_ARB_RR_EN
    win_mem = mem_pend && !(if_pend && lg_mem);
`else
    win_mem = mem_pend;
`endif
    any_req  = if_pend || mem_pend;
    owner_rr = own ? k_mem_rr : k_if_rr;
    if (known) begin
      chk("if_ar_ready",  if_ar_ready,  (phase == 0) && any_req && !win_mem);
      chk("mem_ar_ready", mem_ar_ready, (phase == 0) && win_mem);
      chk("axi_ar_valid", axi_ar_valid, phase == 1);
      chk("axi_ar_burst", axi_ar_burst, 2'b01);
      if (phase == 1) begin
        chk("axi_ar_addr", axi_ar_addr, t_addr);
        chk("axi_ar_len",  axi_ar_len,  t_len);
        chk("axi_ar_size", axi_ar_size, t_size);
        chk("axi_ar_id",   axi_ar_id,   {3'b000, own});
      end
      e_rr = (phase == 2) && owner_rr;
      chk("axi_r_ready", axi_r_ready, e_rr);
      chk("if_r_valid",  if_r_valid,  (phase == 2) && !own && axi_r_valid);
      chk("mem_r_valid", mem_r_valid, (phase == 2) &&  own && axi_r_valid);
      if (phase == 2 && axi_r_valid) begin
        chk("r_data", own ? mem_r_data : if_r_data, h_data);
        chk("r_resp", own ? mem_r_resp : if_r_resp, h_resp);
        chk("r_last", own ? mem_r_last : if_r_last, beat == int'(t_len));
      end
    end

    if (k_reset) begin
      phase = 0; own = 0; lg_mem = 1; r_hold = 0; known = 1;
    end else begin
      case (phase)
        0: if (any_req) begin
          own = win_mem; lg_mem = win_mem; phase = 1;
          if (win_mem) begin t_addr = mem_addr; t_len = mem_len; t_size = mem_size; mem_pend = 0; end
          else         begin t_addr = if_addr;  t_len = if_len;  t_size = if_size;  if_pend = 0;  end
        end
        1: if (k_arready) begin phase = 2; beat = 0; r_hold = 0; end
        default: if (axi_r_valid) begin
          if (owner_rr) begin
            r_hold = 0;
            if (beat == int'(t_len)) phase = 0; else beat++;
          end else begin
            r_hold = 1;
          end
        end
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 300 && !(phase == 0 && !if_pend && !mem_pend)) begin
      rand_knobs(0); step(); i++;
    end
    chk("drain_done", (phase == 0 && !if_pend && !mem_pend), 1);
    quiet();
  endtask

  task automatic req_if_t(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    if_pend = 1; if_addr = a; if_len = l; if_size = s;
  endtask

  task automatic req_mem_t(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    mem_pend = 1; mem_addr = a; mem_len = l; mem_size = s;
  endtask

  initial begin
    if_addr = '0; if_len = '0; if_size = '0; mem_addr = '0; mem_len = '0; mem_size = '0;
    h_data = '0; h_resp = '0; phase = 0; own = 0; beat = 0; lg_mem = 1; r_hold = 0;
    t_addr = '0; t_len = '0; t_size = '0;
    quiet();
    k_reset = 1;
    @(posedge clk); #1;
    step(); step();
    quiet();

    // Reset state
    step();
    chk("rst_ar_valid", s_arv, 0);
    chk("rst_ar_id",    s_arid, 0);
    chk("rst_ar_addr",  s_araddr, 0);

    // Tie: both request together
    req_if_t(64'h8000_0004, 8'd0, 3'd3);
    req_mem_t(64'h8000_1000, 8'd0, 3'd3);
    step();
`ifdef YSYX_22041071_ARB_RR_EN
    chk("tie_first_if_gnt",  s_if_arr,  1);
    chk("tie_first_mem_gnt", s_mem_arr, 0);
`else
    chk("tie_first_mem_gnt", s_mem_arr, 1);
    chk("tie_first_if_gnt",  s_if_arr,  0);
`endif
    k_arready = 1; step();
`ifdef YSYX_22041071_ARB_RR_EN
    chk("tie_first_id", s_arid, 0);
`else
    chk("tie_first_id", s_arid, 1);
`endif
    quiet(); k_rvalid = 1; k_if_rr = 1; k_mem_rr = 1; k_rdata = 64'h55; step();
    quiet(); step();
`ifdef YSYX_22041071_ARB_RR_EN
    chk("tie_second_mem_gnt", s_mem_arr, 1);
`else
    chk("tie_second_if_gnt", s_if_arr, 1);
`endif
    drain();

    // IF only, slave accepts address after two waits
    req_if_t(64'h8000_0000, 8'd0, 3'd3);
    step();
    chk("ifonly_gnt", s_if_arr, 1);
    step();
    chk("ifonly_arv_c1", s_arv, 1);
    step();
    chk("ifonly_arv_c2", s_arv, 1);
    k_arready = 1; step();
    chk("ifonly_arv_c3", s_arv, 1);
    chk("ifonly_id", s_arid, 0);
    chk("ifonly_addr", s_araddr, 64'h8000_0000);
    quiet(); k_rvalid = 1; k_if_rr = 1; k_rdata = 64'h1234; step();
    chk("ifonly_rvalid", s_if_rv, 1);
    chk("ifonly_rdata", s_if_data, 64'h1234);
    chk("ifonly_rlast", s_if_last, 1);
    quiet(); req_mem_t(64'h8000_2000, 8'd0, 3'd2); step();
    chk("turnaround_gnt", s_mem_arr, 1);
    drain();

    // SLVERR forwarded
    req_if_t(64'h8000_0040, 8'd0, 3'd3); step();
    k_arready = 1; step();
    quiet(); k_rvalid = 1; k_if_rr = 1; k_rresp = 2'b10; k_rdata = 64'hDEAD; step();
    chk("err_rvalid", s_if_rv, 1);
    chk("err_resp", s_if_resp, 2'b10);
    quiet(); req_if_t(64'h8000_0080, 8'd0, 3'd3); step();
    chk("err_back_idle", s_if_arr, 1);
    drain();

    // MEM burst of 4 with a stalled second beat
    req_mem_t(64'h8000_1000, 8'd3, 3'd3); step();
    k_arready = 1; step();
    quiet(); k_rvalid = 1; k_mem_rr = 1; k_rdata = 64'hA1; step();
    chk("burst_b1_last", s_mem_last, 0);
    k_mem_rr = 0; k_rdata = 64'hB2; step();
    chk("burst_stall_rready", s_rready, 0);
    chk("burst_stall_valid", s_mem_rv, 1);
    k_mem_rr = 1; k_rdata = 64'hFF; step();
    chk("burst_b2_held", s_mem_data, 64'hB2);
    k_rdata = 64'hC3; step();
    k_rdata = 64'hD4; step();
    chk("burst_b4_data", s_mem_data, 64'hD4);
    chk("burst_b4_last", s_mem_last, 1);
    quiet(); drain();

    // Reset in the middle of a burst
    req_mem_t(64'h8000_3000, 8'd3, 3'd3); step();
    k_arready = 1; step();
    quiet(); k_rvalid = 1; k_mem_rr = 1; k_rdata = 64'h11; step();
    k_mem_rr = 0; k_rdata = 64'h22; k_reset = 1; step();
    quiet(); k_stray = 1; step();
    chk("rstmid_if_arr",  s_if_arr,  0);
    chk("rstmid_mem_arr", s_mem_arr, 0);
    chk("rstmid_arv",     s_arv,     0);
    chk("rstmid_rready",  s_rready,  0);
    chk("rstmid_if_rv",   s_if_rv,   0);
    chk("rstmid_mem_rv",  s_mem_rv,  0);
    chk("rstmid_owner",   s_arid,    0);
    quiet(); req_if_t(64'h8000_0100, 8'd1, 3'd3); step();
    chk("rstmid_new_gnt", s_if_arr, 1);
    drain();

    // Stray R beat while idle
    k_stray = 1; k_rdata = 64'h77; step();
    chk("stray_rready", s_rready, 0);
    chk("stray_if_rv",  s_if_rv,  0);
    chk("stray_mem_rv", s_mem_rv, 0);
    quiet();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      rand_knobs(1);
      if ($urandom_range(0, 499) == 0) k_reset = 1;
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_22041071_axi_rd_arbiter.md
Name: ysyx_22041071_axi_rd_arbiter

Overview:
- Shares the core's single AXI4 read channel (AR + R) between the instruction-fetch requester (IF) and the load/store unit (MEM).
- Grants one requester at a time, registers its AR payload, drives the master AR channel, and steers R beats back to the owner until RLAST.
- Sits between the PC/fetch stage, the LSU and the AXI bridge; exactly one read transaction is outstanding at any time.

Parameters:
- ADDR_W, 64, address width (matches the core address bus).
- DATA_W, 64, R data width.
- LEN_W, 8, AXI burst length field width.
- ID_W, 4, AXI ID width; the ID carries the owner (0 = IF, 1 = MEM).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- if_ar_valid / mem_ar_valid  in  1  read request from each requester
- if_ar_ready / mem_ar_ready  out  1  request accepted (one-cycle grant pulse)
- if_ar_addr / mem_ar_addr  in  ADDR_W  request address
- if_ar_len / mem_ar_len  in  LEN_W  burst length minus 1
- if_ar_size / mem_ar_size  in  3  beat size
- if_r_valid / mem_r_valid  out  1  beat for this requester
- if_r_ready / mem_r_ready  in  1  requester accepts beat
- if_r_data / mem_r_data  out  DATA_W  beat data
- if_r_resp / mem_r_resp  out  2  beat response
- if_r_last / mem_r_last  out  1  final beat
- axi_ar_valid  out  1;  axi_ar_ready  in  1
- axi_ar_addr  out  ADDR_W;  axi_ar_len  out  LEN_W;  axi_ar_size  out  3;  axi_ar_id  out  ID_W;  axi_ar_burst  out  2 (constant INCR, 2'b01)
- axi_r_valid  in  1;  axi_r_ready  out  1;  axi_r_data  in  DATA_W;  axi_r_resp  in  2;  axi_r_last  in  1;  axi_r_id  in  ID_W

Behaviour:
- **States:** IDLE, ADDR, DATA; 2-bit state register plus a 1-bit owner register.
- **Reset:**
  - State goes to IDLE and owner to 0.
  - All valid/ready outputs are 0.
  - The axi_ar_addr/len/size/id registers are 0.
  - Reset mid-transaction abandons the transaction with no drain; the slave is reset by the same signal.
- **IDLE:**
  - If any request is valid, the winner's ar_ready is driven high combinationally in that cycle.
  - The winner's addr/len/size are latched, owner is set, and the state moves to ADDR.
  - Default priority: MEM beats IF when both are valid.
  - A requester that is not granted keeps its valid asserted and its payload stable (AXI rule); the arbiter does not buffer it.
- **ADDR:**
  - axi_ar_valid = 1 with the latched payload; axi_ar_id = owner.
  - On axi_ar_valid & axi_ar_ready, move to DATA.
  - The payload does not change while in ADDR.
- **DATA:**
  - The owner's r_valid equals axi_r_valid; axi_r_ready equals the owner's r_ready.
  - data/resp/last are passed through combinationally.
  - The non-owner's r_valid is 0.
  - On axi_r_valid & axi_r_ready & axi_r_last, move to IDLE.
- **Timing:**
  - Grant-to-axi_ar_valid latency is 1 cycle.
  - Minimum turnaround is 1 cycle: the RLAST handshake cycle is followed by an IDLE cycle, which can grant again.
  - ar_ready is never high outside IDLE.
- **Responses:** SLVERR/DECERR are forwarded unchanged; the arbiter takes no action on them.
- **Protocol checks:**
  - axi_r_valid arriving outside DATA is ignored (axi_r_ready = 0).
  - An axi_r_id that does not match owner is a protocol error and is flagged only by simulation assertion.
- **len = 0:** a single-beat burst; the first beat carries RLAST.

Optional Feature:
- Macro: YSYX_22041071_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant flop is updated at each grant.
  - On a tie, the requester not granted last time wins.
  - last_grant resets to MEM, so IF wins the first tie.
- Undefined: fixed MEM-over-IF priority and no last_grant flop.

Decomposition:
- Shared package/define file holds:
  - State encodings ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2.
  - Owner IDs OWN_IF=0, OWN_MEM=1.
  - AXI burst INCR=2'b01.
  - Resp codes OKAY/SLVERR.
  - Reuse of the existing ADDR_BUS, AXI_LEN_WIDTH and SIZE_D defines.
- One natural sub-module: ysyx_22041071_arb_pick. It is a combinational two-input grant picker that contains the RR_EN logic and the last_grant flop. Everything else stays in the top module.

Test Plan:
- **IF only:** IF requests addr 0x8000_0000, len 0, size 3; slave gives arready after 2 cycles, then one beat data 0x1234, RLAST.
  - Required: if_ar_ready pulses in cycle 0; axi_ar_valid in cycles 1–3 with id 0; if_r_valid with data 0x1234 and last; IDLE one cycle later.
- **Tie:** IF (0x8000_0004) and MEM (0x8000_1000) request in the same cycle.
  - Without RR_EN: MEM is granted first (id 1); IF is granted in the IDLE cycle after MEM's RLAST.
  - With RR_EN: IF first, then MEM.
- **Burst:** MEM len 3; R beats carry RLAST only on beat 4; mem_r_ready is low on beat 2.
  - Required: axi_r_ready is low that cycle and the beat is held; 4 beats delivered in order; if_r_valid stays 0 throughout.
- **Error:** IF read returns resp SLVERR.
  - Required: if_r_resp = 2'b10 is delivered, and the arbiter returns to IDLE normally.
- **Reset mid-DATA:** assert reset during beat 2 of a len-3 burst.
  - Required: next cycle IDLE, all valid/ready outputs 0, owner 0; a new IF request is then granted normally.
- **Stray R:** axi_r_valid asserted while in IDLE.
  - Required: axi_r_ready = 0 and no requester r_valid asserted.
